// File: rtl/pushbutton_reader.sv
// Pushbutton reader: synchronises and debounces active-low KEY pins, latches presses in
// sticky EDGE bits and exposes LEVEL/EDGE/MASK over an Avalon-MM slave with a level interrupt.
module pushbutton_reader #(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq,
    output logic [N_KEYS-1:0] key_level
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        REL_PEND
    } key_state_t;

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] pressed_s;
    logic [N_KEYS-1:0] rise;
    key_state_t        state_q [N_KEYS];
    key_state_t        state_d [N_KEYS];
    logic [CNT_W-1:0]  cnt_q   [N_KEYS];
    logic [CNT_W-1:0]  cnt_d   [N_KEYS];
    logic [N_KEYS-1:0] edge_q;
    logic [N_KEYS-1:0] mask_q;
    logic [N_KEYS-1:0] edge_clr;
    logic [31:0]       read_mux;
    logic              unused_wdata;

    // Sync flops reset to the released (high) pin level so reset never fakes a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign pressed_s = ~sync2;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rise      = '0;
        key_level = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            case (state_q[i])
                RELEASED: begin
                    if (pressed_s[i]) begin
                        state_d[i] = PRESS_PEND;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_PEND: begin
                    if (!pressed_s[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = PRESSED;
                        rise[i]    = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!pressed_s[i]) begin
                        state_d[i] = REL_PEND;
                        cnt_d[i]   = '0;
                    end
                end
                REL_PEND: begin
                    if (pressed_s[i]) begin
                        state_d[i] = PRESSED;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = RELEASED;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = RELEASED;
            endcase
            key_level[i] = (state_q[i] == PRESSED) || (state_q[i] == REL_PEND);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign edge_clr = (avs_write && (avs_address == 2'd1)) ? avs_writedata[N_KEYS-1:0] : '0;

    always_comb begin
        read_mux = '0;
        case (avs_address)
            2'd0:    read_mux[N_KEYS-1:0] = key_level;
            2'd1:    read_mux[N_KEYS-1:0] = edge_q;
            2'd2:    read_mux[N_KEYS-1:0] = mask_q;
            default: read_mux = '0;
        endcase
    end

    // OR-ing rise after the clear makes a same-cycle press win over write-1-to-clear;
    // readdata and irq use pre-update register values.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_q       <= '0;
            mask_q       <= '0;
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            edge_q <= (edge_q & ~edge_clr) | rise;
            if (avs_write && (avs_address == 2'd2)) begin
                mask_q <= avs_writedata[N_KEYS-1:0];
            end
            if (avs_read) begin
                avs_readdata <= read_mux;
            end
            irq <= |(edge_q & mask_q);
        end
    end

    assign unused_wdata = ^avs_writedata;

endmodule

// File: tb/tb_pushbutton_reader.sv
// Self-checking bench for pushbutton_reader: register table, directed debounce/edge corner
// cases and a randomized run, all also compared every cycle against a behavioural model.
module tb_pushbutton_reader;
    localparam int N    = 3;
    localparam int DEB  = 4;
    localparam int RAND_CYCLES = 3000;

    logic          clk;
    logic          reset;
    logic [N-1:0]  key_n;
    logic [1:0]    avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [31:0]   avs_readdata;
    logic          irq;
    logic [N-1:0]  key_level;

    int vectors;
    int miscompares;

    // Behavioural model: a key's debounced level flips once the synchronised input has
    // disagreed with it for DEB+1 consecutive samples; the input seen is the pin 2 clks ago.
    logic [N-1:0]  m_pin1;
    logic [N-1:0]  m_pin2;
    logic [N-1:0]  m_level;
    logic [N-1:0]  m_edge;
    logic [N-1:0]  m_mask;
    logic [31:0]   m_rd;
    logic          m_irq;
    int            m_run [N];

    typedef struct {
        logic [1:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_rd;
    } bus_vec_t;

    bus_vec_t vecs [10];

    pushbutton_reader #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_n         (key_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .key_level     (key_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic modelReset();
        m_pin1  = '1;
        m_pin2  = '1;
        m_level = '0;
        m_edge  = '0;
        m_mask  = '0;
        m_rd    = '0;
        m_irq   = 1'b0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    task automatic modelStep();
        logic [N-1:0] seen;
        logic [N-1:0] rises;
        logic [N-1:0] clr;
        logic [N-1:0] level_old;
        logic [N-1:0] edge_old;
        logic [N-1:0] mask_old;
        if (reset) begin
            modelReset();
            return;
        end
        level_old = m_level;
        edge_old  = m_edge;
        mask_old  = m_mask;
        seen      = ~m_pin2;
        m_pin2    = m_pin1;
        m_pin1    = key_n;
        rises     = '0;
        for (int i = 0; i < N; i++) begin
            if (seen[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB + 1) begin
                    m_level[i] = seen[i];
                    m_run[i]   = 0;
                    rises[i]   = seen[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        clr    = (avs_write && avs_address == 2'd1) ? avs_writedata[N-1:0] : '0;
        m_edge = (edge_old & ~clr) | rises;
        if (avs_write && avs_address == 2'd2) m_mask = avs_writedata[N-1:0];
        m_irq = |(edge_old & mask_old);
        if (avs_read) begin
            case (avs_address)
                2'd0:    m_rd = {29'd0, level_old};
                2'd1:    m_rd = {29'd0, edge_old};
                2'd2:    m_rd = {29'd0, mask_old};
                default: m_rd = 32'd0;
            endcase
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual,
                     expected, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("model_key_level", {29'd0, key_level}, {29'd0, m_level});
        checkOutput("model_irq", {31'd0, irq}, {31'd0, m_irq});
        checkOutput("model_readdata", avs_readdata, m_rd);
    endtask

    // One clock: drive at the falling edge, advance the model, sample at the next falling edge.
    task automatic applyStimulus(input logic rst, input logic [N-1:0] kn, input logic [1:0] addr,
                                 input logic rd, input logic wr, input logic [31:0] wd);
        reset         = rst;
        key_n         = kn;
        avs_address   = addr;
        avs_read      = rd;
        avs_write     = wr;
        avs_writedata = wd;
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkModel();
    endtask

    task automatic idle(input logic [N-1:0] kn, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, kn, 2'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic busRead(input logic [N-1:0] kn, input logic [1:0] addr);
        applyStimulus(1'b0, kn, addr, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic busWrite(input logic [N-1:0] kn, input logic [1:0] addr, input logic [31:0] wd);
        applyStimulus(1'b0, kn, addr, 1'b0, 1'b1, wd);
    endtask

    initial begin
        logic [N-1:0] kn;
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        key_n         = '1;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        modelReset();
        @(negedge clk);

        applyStimulus(1'b1, 3'b111, 2'd0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 3'b111, 2'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("reset_key_level", {29'd0, key_level}, 32'd0);
        checkOutput("reset_irq", {31'd0, irq}, 32'd0);
        checkOutput("reset_readdata", avs_readdata, 32'd0);

        // Register access table, keys idle.
        vecs[0] = '{2'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[1] = '{2'd2, 1'b1, 1'b0, 32'h0,         1'b1, 32'h7};
        vecs[2] = '{2'd3, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0};
        vecs[3] = '{2'd2, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 32'h7};
        vecs[4] = '{2'd2, 1'b1, 1'b0, 32'h0,         1'b1, 32'h2};
        vecs[5] = '{2'd0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h2};
        vecs[6] = '{2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[7] = '{2'd1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[8] = '{2'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[9] = '{2'd2, 1'b1, 1'b1, 32'h0,         1'b1, 32'h2};
        for (int v = 0; v < 10; v++) begin
            applyStimulus(1'b0, 3'b111, vecs[v].addr, vecs[v].rd, vecs[v].wr, vecs[v].wdata);
            if (vecs[v].chk) checkOutput($sformatf("table_%0d", v), avs_readdata, vecs[v].exp_rd);
        end
        busRead(3'b111, 2'd2);
        checkOutput("table_mask_cleared", avs_readdata, 32'h0);

        // Steady press of key 0 appears exactly DEB+2 clocks after the first sampling edge.
        for (int c = 0; c < DEB + 2; c++) begin
            idle(3'b110, 1);
            checkOutput($sformatf("t1_level_early_%0d", c), {29'd0, key_level}, 32'd0);
        end
        idle(3'b110, 1);
        checkOutput("t1_level_on_time", {29'd0, key_level}, 32'd1);
        busRead(3'b110, 2'd1);
        checkOutput("t1_edge", avs_readdata, 32'h1);
        checkOutput("t1_irq_masked", {31'd0, irq}, 32'd0);
        idle(3'b111, DEB + 4);
        checkOutput("t1_level_released", {29'd0, key_level}, 32'd0);
        busRead(3'b111, 2'd1);
        checkOutput("t1_edge_after_release", avs_readdata, 32'h1);
        busWrite(3'b111, 2'd1, 32'h1);
        busRead(3'b111, 2'd1);
        checkOutput("t1_edge_cleared", avs_readdata, 32'h0);

        // Short bounce on key 1 is rejected.
        idle(3'b101, 3);
        for (int c = 0; c < 10; c++) begin
            idle(3'b111, 1);
            checkOutput($sformatf("t2_level_%0d", c), {29'd0, key_level}, 32'd0);
            checkOutput($sformatf("t2_irq_%0d", c), {31'd0, irq}, 32'd0);
        end
        busRead(3'b111, 2'd1);
        checkOutput("t2_edge", avs_readdata, 32'h0);

        // Interrupt on an unmasked press, then clear; no auto-repeat while held.
        busWrite(3'b111, 2'd2, 32'h4);
        idle(3'b011, DEB + 4);
        checkOutput("t3_irq_set", {31'd0, irq}, 32'd1);
        busWrite(3'b011, 2'd1, 32'h4);
        idle(3'b011, 1);
        checkOutput("t3_irq_cleared", {31'd0, irq}, 32'd0);
        busWrite(3'b011, 2'd1, 32'h1);
        busRead(3'b011, 2'd1);
        checkOutput("t3_edge_w1c_noop", avs_readdata, 32'h0);
        idle(3'b011, 6);
        busRead(3'b011, 2'd1);
        checkOutput("t3_no_repeat", avs_readdata, 32'h0);
        checkOutput("t3_irq_held", {31'd0, irq}, 32'd0);
        idle(3'b111, DEB + 4);

        // Clear of bit 0 in the same clock as a new rise: set wins.
        idle(3'b110, DEB + 2);
        busWrite(3'b110, 2'd1, 32'h1);
        checkOutput("t4_level", {29'd0, key_level}, 32'd1);
        busRead(3'b110, 2'd1);
        checkOutput("t4_edge_set_wins", avs_readdata, 32'h1);
        idle(3'b111, DEB + 4);
        busWrite(3'b111, 2'd1, 32'h1);

        // Reset while key 0 sits in its pending window with cnt=2.
        busRead(3'b110, 2'd2);
        checkOutput("t5_mask_before", avs_readdata, 32'h4);
        idle(3'b110, 4);
        applyStimulus(1'b1, 3'b110, 2'd0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 3'b110, 2'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("t5_reset_level", {29'd0, key_level}, 32'd0);
        checkOutput("t5_reset_irq", {31'd0, irq}, 32'd0);
        checkOutput("t5_reset_readdata", avs_readdata, 32'd0);
        for (int c = 0; c < DEB + 2; c++) begin
            idle(3'b110, 1);
            checkOutput($sformatf("t5_level_early_%0d", c), {29'd0, key_level}, 32'd0);
        end
        idle(3'b110, 1);
        checkOutput("t5_level_requalified", {29'd0, key_level}, 32'd1);
        busRead(3'b110, 2'd2);
        checkOutput("t5_mask_reset", avs_readdata, 32'h0);
        idle(3'b111, DEB + 4);

        // Randomized run against the model, with occasional resets.
        kn = 3'b111;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) kn[i] = ~kn[i];
            end
            applyStimulus(($urandom_range(0, 399) == 0), kn, 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
